packet_send: RTL and testbench
==============================

PACKET_SEND -- requirements
Module: packet_send

Interface
REQ-001 SHALL have parameter LEAD_CYCLES, default 3, meaning the number of cycles start_o is held low before the first bit of each packet.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued 4-bit packets.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 pkt_i  input  4  packet {dest[1:0], payload[1:0]}; dest selects the receiver buffer (00 to buffer 1 ... 11 to buffer 4).
REQ-007 pkt_valid_i  input  1  packet offered this cycle.
REQ-008 pkt_ready_o  output  1  FIFO can accept; transfer occurs when pkt_valid_i and pkt_ready_o are both 1.
REQ-009 start_o  output  1  link start line; low during the lead-in, high otherwise.
REQ-010 key0_o  output  1  active-low button line 0.
REQ-011 key1_o  output  1  active-low button line 1.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 fifo_level_o  output  3  number of queued packets, 0..FIFO_DEPTH.
REQ-014 sent_count_o  output  8  packets fully transmitted, wraps modulo 256.
REQ-015 ones_count_o  output  8  '1' bits transmitted, wraps modulo 256.

Function
REQ-016 Line encoding SHALL be: bit 0 as {key0_o,key1_o}=10; bit 1 as 01; idle/gap as 11; 00 is never driven.
REQ-017 The FIFO SHALL assert pkt_ready_o = (fifo_level_o != FIFO_DEPTH), combinationally from registered level.
REQ-018 An accepted packet SHALL be visible in fifo_level_o on the following cycle.
REQ-019 A push and a pop in the same cycle SHALL leave the level unchanged and preserve FIFO order.
REQ-020 Pops SHALL occur only from a non-empty FIFO; pushes SHALL be ignored when pkt_ready_o=0.
REQ-021 The FSM SHALL have states IDLE, LEAD, BIT, GAP.
REQ-022 IDLE: start_o=1, keys=11. If the FIFO is non-empty, pop the head into a 4-bit shift register, clear the bit index to 3, and go to LEAD.
REQ-023 LEAD: start_o=0, keys=11, for exactly LEAD_CYCLES cycles, then go to BIT.
REQ-024 BIT: start_o=1; drive shift[idx] per REQ-016 for exactly 1 cycle; if the bit is 1, increment ones_count_o; then go to GAP.
REQ-025 GAP: start_o=1, keys=11, for 1 cycle; if idx=0, increment sent_count_o and go to IDLE; else decrement idx and go to BIT.
REQ-026 Bit order SHALL be MSB first: pkt[3], pkt[2], pkt[1], pkt[0].
REQ-027 Packet latency, accept at cycle 0 into an empty idle block: pop at cycle 1; LEAD at cycles 2..4; bits at cycles 5, 7, 9, 11; gaps at cycles 6, 8, 10, 12; IDLE at cycle 13.
REQ-028 Back-to-back queued packets SHALL each spend exactly 1 IDLE cycle between them, where the pop occurs.
REQ-029 All outputs SHALL be registered except pkt_ready_o.
REQ-030 Counters SHALL wrap 255 to 0 without a flag.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, FIFO empty, fifo_level_o=0, sent_count_o=0, ones_count_o=0, start_o=1, key0_o=1, key1_o=1, busy_o=0, pkt_ready_o=1.
REQ-032 Reset asserted mid-packet SHALL abort it on that edge; no partial count updates; the aborted packet and all queued packets are discarded.
REQ-033 A packet offered in the same cycle as rst=1 SHALL NOT be accepted.

Verification
REQ-034 Single packet 4'b1011 from reset: start_o low at cycles 2..4; key pairs 01,11,10,11,01,11,01,11 at cycles 5..12; sent_count_o=1; ones_count_o=3.
REQ-035 Push 5 packets with valid held high while the FIFO is full and the FSM is stalled: pkt_ready_o=0 once level=4; the 5th packet enters only after a pop; all 5 are transmitted in order.
REQ-036 Simultaneous push and pop at level 4 is impossible; at level 2, the level stays 2 and order is verified on the line.
REQ-037 Assert rst during the BIT state of the 2nd bit: next cycle all outputs match REQ-031; later traffic is correct.
REQ-038 Transmit 64 packets of 4'b1111: ones_count_o wraps to 0; sent_count_o=64.
REQ-039 Line monitor on all runs: {key0_o,key1_o} never equals 00; keys stay 11 whenever start_o=0.

Source files
------------

// File: rtl/packet_send.sv
// Serialises queued 4-bit packets onto a two-wire key link, preceded by a low start lead-in.
// LEAD_CYCLES must be at least 1; FIFO_DEPTH must fit the 3-bit level output (1..7).
module packet_send #(
  parameter int unsigned LEAD_CYCLES = 3,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pkt_i,
  input  logic       pkt_valid_i,
  output logic       pkt_ready_o,
  output logic       start_o,
  output logic       key0_o,
  output logic       key1_o,
  output logic       busy_o,
  output logic [2:0] fifo_level_o,
  output logic [7:0] sent_count_o,
  output logic [7:0] ones_count_o
);

  typedef enum logic [1:0] {StIdle, StLead, StBit, StGap} state_e;

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LeadW = (LEAD_CYCLES > 1) ? $clog2(LEAD_CYCLES) : 1;
  localparam logic [2:0]       DepthL   = 3'(FIFO_DEPTH);
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [LeadW-1:0] LeadLast = LeadW'(LEAD_CYCLES - 1);

  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]       level_q;
  logic             push, pop;

  state_e           state_q, state_d;
  logic [3:0]       shift_q, shift_d;
  logic [1:0]       idx_q, idx_d;
  logic [LeadW-1:0] lead_q, lead_d;
  logic [7:0]       sent_q, sent_d, ones_q, ones_d;
  logic             start_q, start_d, busy_q, busy_d;
  logic [1:0]       keys_q, keys_d;

  assign pkt_ready_o = (level_q != DepthL);
  assign push        = pkt_valid_i && pkt_ready_o;
  assign pop         = (state_q == StIdle) && (level_q != 3'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pkt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 3'd1;
      end else if (!push && pop) begin
        level_q <= level_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    lead_d  = lead_q;
    sent_d  = sent_q;
    ones_d  = ones_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          idx_d   = 2'd3;
          lead_d  = LeadLast;
          state_d = StLead;
        end
      end
      StLead: begin
        if (lead_q == '0) begin
          state_d = StBit;
        end else begin
          lead_d = lead_q - 1'b1;
        end
      end
      StBit: begin
        if (shift_q[idx_q]) begin
          ones_d = ones_q + 8'd1;
        end
        state_d = StGap;
      end
      StGap: begin
        if (idx_q == 2'd0) begin
          sent_d  = sent_q + 8'd1;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q - 2'd1;
          state_d = StBit;
        end
      end
    endcase

    // Line outputs are derived from the next state so they can be registered with it.
    start_d = (state_d != StLead);
    busy_d  = (state_d != StIdle);
    keys_d  = 2'b11;
    if (state_d == StBit) begin
      keys_d = shift_d[idx_d] ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= 4'd0;
      idx_q   <= 2'd0;
      lead_q  <= '0;
      sent_q  <= 8'd0;
      ones_q  <= 8'd0;
      start_q <= 1'b1;
      busy_q  <= 1'b0;
      keys_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      lead_q  <= lead_d;
      sent_q  <= sent_d;
      ones_q  <= ones_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      keys_q  <= keys_d;
    end
  end

  assign start_o      = start_q;
  assign key0_o       = keys_q[1];
  assign key1_o       = keys_q[0];
  assign busy_o       = busy_q;
  assign fifo_level_o = level_q;
  assign sent_count_o = sent_q;
  assign ones_count_o = ones_q;

endmodule

// File: tb/tb_packet_send.sv
// Directed bench for packet_send: expected line bits are queued on acceptance and
// consumed by a line monitor; directed checks cover timing, levels, counters and reset.
module tb_packet_send;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pkt;
  logic       pkt_valid;
  logic       pkt_ready, start, key0, key1, busy;
  logic [2:0] level;
  logic [7:0] sent, ones;
  logic [1:0] keys;

  int n_checks = 0;
  int n_pass   = 0;
  bit sb[$];

  assign keys = {key0, key1};

  packet_send #(.LEAD_CYCLES(3), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_i        (pkt),
    .pkt_valid_i  (pkt_valid),
    .pkt_ready_o  (pkt_ready),
    .start_o      (start),
    .key0_o       (key0),
    .key1_o       (key1),
    .busy_o       (busy),
    .fifo_level_o (level),
    .sent_count_o (sent),
    .ones_count_o (ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Line monitor: every non-idle key pair is a transmitted bit and must match the queue head.
  always @(negedge clk) begin
    logic bad;
    bit   e;
    bad = (keys == 2'b00) || (!start && keys != 2'b11);
    check("line_rule", {31'd0, bad}, 32'd0);
    if (keys == 2'b01 || keys == 2'b10) begin
      if (sb.size() == 0) begin
        check("line_bit_unexpected", {30'd0, keys}, 32'd3);
      end else begin
        e = sb.pop_front();
        check("line_bit", {30'd0, keys}, e ? 32'd1 : 32'd2);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with valid still high.
  task automatic send(input logic [3:0] p);
    int w = 0;
    pkt = p;
    pkt_valid = 1'b1;
    while (!pkt_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("send_ready", {31'd0, pkt_ready}, 32'd1);
    for (int i = 3; i >= 0; i--) sb.push_back(p[i]);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!busy && level == 3'd0) break;
      @(negedge clk);
    end
    check("wait_idle", {28'd0, busy, level}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_start", {31'd0, start}, 32'd1);
    check("rst_keys", {30'd0, keys}, 32'd3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_sent", {24'd0, sent}, 32'd0);
    check("rst_ones", {24'd0, ones}, 32'd0);
    check("rst_ready", {31'd0, pkt_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp_keys [8];

  initial begin
    exp_keys[0] = 2'b01; exp_keys[1] = 2'b11; exp_keys[2] = 2'b10; exp_keys[3] = 2'b11;
    exp_keys[4] = 2'b01; exp_keys[5] = 2'b11; exp_keys[6] = 2'b01; exp_keys[7] = 2'b11;
    rst = 1'b1;
    pkt = 4'hF;
    pkt_valid = 1'b1;  // offered during reset: must be dropped
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    pkt_valid = 1'b0;
    @(negedge clk);
    check("rst_offer_dropped", {29'd0, level}, 32'd0);

    // Single packet 1011: cycle-exact timing.
    pkt = 4'b1011;
    pkt_valid = 1'b1;
    check("c0_ready", {31'd0, pkt_ready}, 32'd1);
    for (int i = 3; i >= 0; i--) sb.push_back(pkt[i]);
    @(negedge clk);
    pkt_valid = 1'b0;
    check("c1_level", {29'd0, level}, 32'd1);
    check("c1_busy", {31'd0, busy}, 32'd0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("lead_start", {30'd0, start, busy}, 32'd1);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("bit_keys", {30'd0, keys}, {30'd0, exp_keys[c]});
    end
    @(negedge clk);
    check("c13_busy", {31'd0, busy}, 32'd0);
    check("c13_sent", {24'd0, sent}, 32'd1);
    check("c13_ones", {24'd0, ones}, 32'd3);

    // Fill the FIFO while transmitting; fifth packet waits for a pop.
    send(4'h0);
    pkt_valid = 1'b0;
    @(negedge clk);
    send(4'h1);
    send(4'h2);
    send(4'h4);
    send(4'h8);
    check("full_level", {29'd0, level}, 32'd4);
    check("full_ready", {31'd0, pkt_ready}, 32'd0);
    send(4'h3);
    pkt_valid = 1'b0;
    check("after_pop_level", {29'd0, level}, 32'd4);
    wait_idle();
    check("fill_sent", {24'd0, sent}, 32'd7);
    check("fill_ones", {24'd0, ones}, 32'd9);

    // Push coinciding with a pop at level 2.
    send(4'h5);
    send(4'hA);
    send(4'h6);
    pkt_valid = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("pp_level_pre", {28'd0, busy, level}, 32'd2);
    pkt = 4'h9;
    pkt_valid = 1'b1;
    for (int i = 3; i >= 0; i--) sb.push_back(pkt[i]);
    @(negedge clk);
    pkt_valid = 1'b0;
    check("pp_level_post", {29'd0, level}, 32'd2);
    wait_idle();
    check("pp_sent", {24'd0, sent}, 32'd11);
    check("pp_ones", {24'd0, ones}, 32'd17);

    // Reset during the second bit of 1100 with another packet queued.
    send(4'hC);
    send(4'h3);
    pkt_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_bit2", {30'd0, keys}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    send(4'h6);
    pkt_valid = 1'b0;
    wait_idle();
    check("post_rst_sent", {24'd0, sent}, 32'd1);
    check("post_rst_ones", {24'd0, ones}, 32'd2);

    // 64 x 1111: ones counter wraps to 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 64; n++) send(4'hF);
    pkt_valid = 1'b0;
    wait_idle();
    check("wrap_ones", {24'd0, ones}, 32'd0);
    check("wrap_sent", {24'd0, sent}, 32'd64);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
